// File: rtl/div_core_pkg.sv
// rtl/div_core_pkg.sv - shared divider definitions: state encodings, bus widths, handshake constants
package div_core_pkg;

  localparam int DIV_BUS_W        = 32;
  localparam int DIV_RESULT_BUS_W = 2 * DIV_BUS_W;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one combinational restoring shift-subtract iteration
module div_step #(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] rem,
  input  logic [DATA_W-1:0] dividend,
  input  logic [DATA_W-1:0] divisor,
  output logic [DATA_W-1:0] rem_next,
  output logic [DATA_W-1:0] quot_next
);

  logic [DATA_W:0] shifted;
  logic [DATA_W:0] trial;

  // Extra top bit keeps the trial exact even when the shifted remainder reaches 2^DATA_W
  always_comb begin
    shifted   = {rem, dividend[DATA_W-1]};
    trial     = shifted - {1'b0, divisor};
    rem_next  = trial[DATA_W] ? shifted[DATA_W-1:0] : trial[DATA_W-1:0];
    quot_next = {dividend[DATA_W-2:0], ~trial[DATA_W]};
  end

endmodule

// File: rtl/div_core.sv
// rtl/div_core.sv - multi-cycle radix-2 restoring divider for DIV/DIVU
module div_core
  import div_core_pkg::*;
#(
  parameter int DATA_W = DIV_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  signed_flag,
  input  logic [DATA_W-1:0]     opdata1,
  input  logic [DATA_W-1:0]     opdata2,
  input  logic                  start_flag,
  input  logic                  cancel_flag,
  output logic                  complete_flag,
  output logic [2*DATA_W-1:0]   div_result
);

  localparam int CNT_W = $clog2(DATA_W);

  div_state_e        state_q, state_d;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] rem_q, dvd_q, dvs_q;
  logic              sign1_q, sign2_q, signed_q;
  logic [DATA_W-1:0] rem_next, quot_next, rem_fix, quot_fix, mag1, mag2;
  logic              start_req, last_iter;

  assign start_req = (start_flag == DivStart) && !cancel_flag;
  assign last_iter = (count_q == CNT_W'(DATA_W - 1));

  // Operand magnitudes; only signed requests with a negative operand are negated
  always_comb begin
    mag1 = (signed_flag && opdata1[DATA_W-1]) ? -opdata1 : opdata1;
    mag2 = (signed_flag && opdata2[DATA_W-1]) ? -opdata2 : opdata2;
  end

  div_step #(.DATA_W(DATA_W)) u_step (
    .rem       (rem_q),
    .dividend  (dvd_q),
    .divisor   (dvs_q),
    .rem_next  (rem_next),
    .quot_next (quot_next)
  );

  // Sign fix: quotient negative when signs differ, remainder follows the dividend
  always_comb begin
    quot_fix = (signed_q && (sign1_q ^ sign2_q)) ? -quot_next : quot_next;
    rem_fix  = (signed_q && sign1_q) ? -rem_next : rem_next;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= DivFree;
    else        state_q <= state_d;
  end

  // Next-state logic; cancel wins over completion
  always_comb begin
    state_d = state_q;
    case (state_q)
      DivFree:   if (start_req) state_d = (opdata2 == '0) ? DivByZero : DivOn;
      DivByZero: state_d = cancel_flag ? DivFree : DivEnd;
      DivOn: begin
        if (cancel_flag)    state_d = DivFree;
        else if (last_iter) state_d = DivEnd;
      end
      DivEnd:    if (cancel_flag || start_flag == DivStop) state_d = DivFree;
      default:   state_d = DivFree;
    endcase
  end

  // Datapath: operand capture, iteration, result load and handshake flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q       <= '0;
      rem_q         <= '0;
      dvd_q         <= '0;
      dvs_q         <= '0;
      sign1_q       <= 1'b0;
      sign2_q       <= 1'b0;
      signed_q      <= 1'b0;
      complete_flag <= DivResultNotReady;
      div_result    <= '0;
    end else begin
      case (state_q)
        DivFree: begin
          complete_flag <= DivResultNotReady;
          if (start_req && opdata2 != '0) begin
            dvd_q    <= mag1;
            dvs_q    <= mag2;
            rem_q    <= '0;
            count_q  <= '0;
            sign1_q  <= opdata1[DATA_W-1];
            sign2_q  <= opdata2[DATA_W-1];
            signed_q <= signed_flag;
          end
        end
        DivByZero: begin
          if (cancel_flag) begin
            complete_flag <= DivResultNotReady;
          end else begin
            div_result    <= '0;
            complete_flag <= DivResultReady;
          end
        end
        DivOn: begin
          if (cancel_flag) begin
            complete_flag <= DivResultNotReady;
          end else begin
            rem_q   <= rem_next;
            dvd_q   <= quot_next;
            count_q <= count_q + 1'b1;
            if (last_iter) begin
              div_result    <= {rem_fix, quot_fix};
              complete_flag <= DivResultReady;
            end
          end
        end
        DivEnd: begin
          if (cancel_flag || start_flag == DivStop) complete_flag <= DivResultNotReady;
        end
        default: complete_flag <= DivResultNotReady;
      endcase
    end
  end

endmodule

// File: tb/tb_div_core.sv
// tb/tb_div_core.sv - scoreboard bench for div_core
module tb_div_core;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        signed_flag = 1'b0;
  logic [31:0] opdata1 = '0;
  logic [31:0] opdata2 = '0;
  logic        start_flag = 1'b0;
  logic        cancel_flag = 1'b0;
  logic        complete_flag;
  logic [63:0] div_result;

  int          checks = 0;
  int          failures = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  div_core #(.DATA_W(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .signed_flag   (signed_flag),
    .opdata1       (opdata1),
    .opdata2       (opdata2),
    .start_flag    (start_flag),
    .cancel_flag   (cancel_flag),
    .complete_flag (complete_flag),
    .div_result    (div_result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] model(input logic s, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) return 64'd0;
    if (s) begin
      if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        q = 32'h8000_0000;
        r = 32'h0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  task automatic run_div(input string tag, input logic s, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input int lat, input int hold);
    int          edges;
    logic [63:0] e, held;
    exp_q.push_back(exp);
    signed_flag = s;
    opdata1     = a;
    opdata2     = b;
    start_flag  = 1'b1;
    edges       = 0;
    do begin
      @(posedge clk);
      edges++;
      @(negedge clk);
      if (edges == 1) begin
        opdata1     = ~a;
        opdata2     = $urandom;
        signed_flag = ~s;
      end
    end while (!complete_flag && edges < 100);
    check({tag, " latency"}, 64'(edges), 64'(lat));
    e = exp_q.pop_front();
    check({tag, " result"}, div_result, e);
    held = div_result;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      check({tag, " hold flag"}, 64'(complete_flag), 64'd1);
      check({tag, " hold result"}, div_result, held);
    end
    start_flag = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check({tag, " drop flag"}, 64'(complete_flag), 64'd0);
    check({tag, " drop result"}, div_result, held);
  endtask

  initial begin
    logic        seen;
    logic        s;
    logic [31:0] a, b;

    #12;
    check("reset flag", 64'(complete_flag), 64'd0);
    check("reset result", div_result, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_div("u100_7", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);
    run_div("s-7_2", 1'b1, 32'hFFFF_FFF9, 32'h2, 64'hFFFFFFFF_FFFFFFFD, 33, 0);
    run_div("s7_-2", 1'b1, 32'h7, 32'hFFFF_FFFE, 64'h00000001_FFFFFFFD, 33, 0);
    run_div("div0", 1'b0, 32'd5, 32'd0, 64'd0, 2, 0);
    run_div("s_ovf", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 64'h00000000_80000000, 33, 0);
    run_div("uffff_1", 1'b0, 32'hFFFF_FFFF, 32'h1, 64'h00000000_FFFFFFFF, 33, 5);
    run_div("restart9_3", 1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 33, 0);

    // Cancel after ten iterations: the flag must never rise
    seen        = 1'b0;
    signed_flag = 1'b0;
    opdata1     = 32'd100;
    opdata2     = 32'd7;
    start_flag  = 1'b1;
    for (int i = 0; i < 11; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen |= complete_flag;
    end
    cancel_flag = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cancel_flag = 1'b0;
    start_flag  = 1'b0;
    check("cancel flag", 64'(complete_flag), 64'd0);
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      @(negedge clk);
      seen |= complete_flag;
    end
    check("cancel never done", 64'(seen), 64'd0);
    check("cancel result kept", div_result, 64'h00000000_00000003);

    // Asynchronous reset mid-operation
    opdata1    = 32'd100;
    opdata2    = 32'd7;
    start_flag = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async rst flag", 64'(complete_flag), 64'd0);
    check("async rst result", div_result, 64'd0);
    start_flag = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_div("u100_7 again", 1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 33, 0);

    for (int i = 0; i < 6; i++) begin
      s = 1'($urandom_range(0, 1));
      a = $urandom;
      b = $urandom >> $urandom_range(0, 31);
      run_div($sformatf("rand%0d", i), s, a, b, model(s, a, b), (b == 0) ? 2 : 33, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_core.md
Name: div_core

Overview:
- Multi-cycle radix-2 restoring divider. It is the responder side of the execute stage's divide handshake: `start_flag`/`cancel_flag`/operands in, `complete_flag`/`div_result` out.
- Serves DIV/DIVU. The execute stage holds the pipeline stalled through the ctrl block until `complete_flag`, then writes `div_result` into HI/LO.
- Processes one quotient bit per clock.

Parameters:
- DATA_W, 32, operand width; `div_result` is 2*DATA_W.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- signed_flag  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled at start.
- opdata1  input  DATA_W  dividend; sampled at start.
- opdata2  input  DATA_W  divisor; sampled at start.
- start_flag  input  1  request; held high by the initiator until it has consumed the result.
- cancel_flag  input  1  abort the current operation (pipeline flush).
- complete_flag  output  1  registered; result valid.
- div_result  output  2*DATA_W  registered; [2*DATA_W-1:DATA_W] = remainder (HI), [DATA_W-1:0] = quotient (LO).

Behaviour:
- Reset (asynchronous, rst_n=0): state=IDLE, complete_flag=0, div_result=0, counter=0, internal registers=0. Reset mid-operation discards all work immediately.
- States: IDLE, DIVZERO, BUSY, DONE.
- IDLE:
  - start_flag=1 and cancel_flag=0, opdata2==0 -> DIVZERO.
  - start_flag=1 and cancel_flag=0, otherwise -> BUSY. On this edge: latch |opdata1| and |opdata2| (two's-complement magnitude only if signed_flag and the MSB are set), latch both operand signs and signed_flag, clear the partial remainder, counter=0.
  - complete_flag=0.
- DIVZERO: next edge -> DONE; div_result=0, complete_flag=1.
- BUSY, one iteration per edge:
  - Shift {rem, dividend} left by 1.
  - Trial = rem_shifted - divisor, width DATA_W+1.
  - Trial non-negative: rem = trial, quotient bit = 1. Otherwise quotient bit = 0.
  - counter increments on each iteration.
- BUSY completion: on the edge completing iteration DATA_W (counter==DATA_W-1):
  - Apply sign fix. Quotient is negated if signed and the operand signs differ. Remainder is negated if signed and the dividend is negative (remainder sign follows the dividend).
  - Load div_result, complete_flag=1, -> DONE.
- Latency: start sampled at edge E0; complete_flag is visible after edge E0+DATA_W (33 edges for DATA_W=32). For divide-by-zero, visible after E0+1.
- DONE:
  - complete_flag and div_result are held while start_flag=1.
  - start_flag=0 -> IDLE next edge; complete_flag cleared, div_result held.
  - A new operation requires at least one cycle of start_flag=0 after DONE.
- cancel_flag=1 in BUSY, DIVZERO or DONE: -> IDLE next edge, complete_flag=0. cancel_flag has priority over completion on the same edge.
- cancel_flag=1 with start_flag=1 in IDLE: the request is ignored.
- Operand changes after E0 are ignored.
- Signed overflow (0x80000000 / 0xFFFFFFFF): quotient=0x80000000, remainder=0, no exception.
- Unsigned magnitudes: 0x80000000 is handled via the DATA_W+1 trial width.

Decomposition:
- Shared define package: state encodings (DivFree, DivByZero, DivOn, DivEnd), DivBus width (DATA_W), DivResultBus width (2*DATA_W), and the DivStart/DivStop and DivResultReady/DivResultNotReady constants used by the execute stage.
- One natural sub-module: div_step, a combinational single shift-subtract iteration. Inputs: rem, dividend, divisor. Outputs: next rem, next dividend/quotient. div_core instantiates it once and iterates.
- Sign fix stays inline in div_core.

Test Plan:
- Unsigned 100/7 (signed_flag=0) -> complete_flag after 33 edges; div_result=64'h00000002_0000000E.
- Signed -7/2 (0xFFFFFFF9, 0x2) -> div_result=64'hFFFFFFFF_FFFFFFFD; signed 7/-2 -> 64'h00000001_FFFFFFFD.
- Divide by zero, 5/0 -> complete_flag after 2 edges; div_result=0.
- Signed 0x80000000/0xFFFFFFFF -> 64'h00000000_80000000. Unsigned 0xFFFFFFFF/1 -> 64'h00000000_FFFFFFFF.
- Handshake: hold start_flag 5 cycles past complete -> result and flag stable; drop start -> complete_flag=0 next edge. Immediate restart 9/3 -> 64'h00000000_00000003.
- cancel_flag pulsed at BUSY iteration 10 -> IDLE, complete_flag never asserted. Async rst_n pulse during BUSY -> all outputs 0 immediately. Subsequent 100/7 succeeds.
